// File: rtl/csi_sequence_parser_if.sv
// Byte-in / command-record-out bundle for csi_sequence_parser.
// master: the parser side; slave: the UART feeder plus the command consumer.
interface csi_sequence_parser_if #(
  parameter int PARAM_W    = 8,
  parameter int MAX_PARAMS = 4
);
  localparam int NP_W = $clog2(MAX_PARAMS + 1);

  logic [7:0]                    in_data;
  logic                          in_valid;
  logic                          in_ready;
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [1:0]                    cmd_kind;
  logic [7:0]                    cmd_final;
  logic [7:0]                    cmd_inter;
  logic [7:0]                    cmd_private;
  logic [NP_W-1:0]               cmd_nparams;
  logic [MAX_PARAMS*PARAM_W-1:0] cmd_params;
  logic [MAX_PARAMS-1:0]         cmd_default;
  logic                          cmd_overflow;

  modport master (
    input  in_data, in_valid, cmd_ready,
    output in_ready, cmd_valid, cmd_kind, cmd_final, cmd_inter, cmd_private,
           cmd_nparams, cmd_params, cmd_default, cmd_overflow
  );

  modport slave (
    output in_data, in_valid, cmd_ready,
    input  in_ready, cmd_valid, cmd_kind, cmd_final, cmd_inter, cmd_private,
           cmd_nparams, cmd_params, cmd_default, cmd_overflow
  );
endinterface

// File: rtl/csi_sequence_parser.sv
// VT100/ANSI byte-stream parser: PRINT / ESC / CSI records over valid/ready.
// Define CSI_PARSER_C1_EN to honour the 8-bit C1 controls 0x9B (CSI) and 0x9C (cancel).
module csi_sequence_parser #(
  parameter int PARAM_W    = 8,
  parameter int MAX_PARAMS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  csi_sequence_parser_if.master  bus
);
  localparam int NP_W   = $clog2(MAX_PARAMS + 1);
  localparam int WIDE_W = PARAM_W + 4;
  localparam logic [NP_W-1:0]   NP_MAX  = NP_W'(MAX_PARAMS);
  localparam logic [NP_W-1:0]   NP_LAST = NP_W'(MAX_PARAMS - 1);
  localparam logic [WIDE_W-1:0] SAT     = {4'b0, {PARAM_W{1'b1}}};

  typedef enum logic [2:0] {
    GROUND, ESCAPE, ESC_INTER, CSI_ENTRY, CSI_PARAM, CSI_INTER, CSI_IGNORE
  } state_t;

  typedef enum logic [1:0] {KIND_PRINT = 2'd0, KIND_ESC = 2'd1, KIND_CSI = 2'd2} kind_t;

  state_t              state_q, state_d;
  logic [PARAM_W-1:0]  params_q [MAX_PARAMS];
  logic [PARAM_W-1:0]  params_d [MAX_PARAMS];
  logic [MAX_PARAMS-1:0] has_digit_q, has_digit_d;
  logic [NP_W-1:0]     idx_q, idx_d;
  logic                seen_q, seen_d, have_inter_q, have_inter_d, ovf_q, ovf_d;
  logic [7:0]          inter_q, inter_d, private_q, private_d;

  logic        accept, emit, clear;
  kind_t       emit_kind;
  logic [7:0]  b;
  logic [WIDE_W-1:0] wide;
  logic [NP_W-1:0]   nparams;
  logic [MAX_PARAMS*PARAM_W-1:0] params_flat;
  logic is_c0, is_inter, is_digit, is_semi, is_colon, is_private, is_final, is_high;
  logic is_cancel, is_c1_csi;

  assign b            = bus.in_data;
  assign bus.in_ready = !bus.cmd_valid || bus.cmd_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign is_c0      = b < 8'h20;
  assign is_inter   = (b >= 8'h20) && (b <= 8'h2F);
  assign is_digit   = (b >= 8'h30) && (b <= 8'h39);
  assign is_colon   = b == 8'h3A;
  assign is_semi    = b == 8'h3B;
  assign is_private = (b >= 8'h3C) && (b <= 8'h3F);
  assign is_final   = (b >= 8'h40) && (b <= 8'h7E);
  assign is_high    = b >= 8'h7F;

`ifdef CSI_PARSER_C1_EN
  assign is_cancel = (b == 8'h18) || (b == 8'h1A) || (b == 8'h9C);
  assign is_c1_csi = b == 8'h9B;
`else
  assign is_cancel = (b == 8'h18) || (b == 8'h1A);
  assign is_c1_csi = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets its default first, so no path can infer a latch.
    state_d      = state_q;
    params_d     = params_q;
    has_digit_d  = has_digit_q;
    idx_d        = idx_q;
    seen_d       = seen_q;
    inter_d      = inter_q;
    have_inter_d = have_inter_q;
    private_d    = private_q;
    ovf_d        = ovf_q;
    emit         = 1'b0;
    emit_kind    = KIND_PRINT;
    clear        = 1'b0;
    wide         = '0;

    if (accept) begin
      if (is_cancel) begin
        state_d = GROUND;
        clear   = 1'b1;
      end else if (b == 8'h1B) begin
        state_d = ESCAPE;
        clear   = 1'b1;
      end else if (is_c1_csi) begin
        state_d = CSI_ENTRY;
        clear   = 1'b1;
      end else if (state_q == GROUND || is_c0) begin
        emit = 1'b1;
      end else if (!is_high) begin
        case (state_q)
          ESCAPE, ESC_INTER: begin
            if (state_q == ESCAPE && b == 8'h5B) begin
              state_d = CSI_ENTRY;
            end else if (is_inter) begin
              inter_d      = b;
              have_inter_d = 1'b1;
              ovf_d        = ovf_q | have_inter_q;
              state_d      = ESC_INTER;
            end else begin
              emit      = 1'b1;
              emit_kind = KIND_ESC;
              clear     = 1'b1;
              state_d   = GROUND;
            end
          end
          CSI_ENTRY, CSI_PARAM: begin
            if (state_q == CSI_ENTRY && is_private) begin
              private_d = b;
              state_d   = CSI_PARAM;
            end else if (is_digit) begin
              seen_d  = 1'b1;
              state_d = CSI_PARAM;
              // Fields past the last slot match no index, so their digits vanish.
              for (int i = 0; i < MAX_PARAMS; i++) begin
                if (idx_q == NP_W'(i)) begin
                  wide = ({4'b0, params_q[i]} << 3) + ({4'b0, params_q[i]} << 1)
                       + WIDE_W'(b[3:0]);
                  has_digit_d[i] = 1'b1;
                  if (wide > SAT) begin
                    params_d[i] = {PARAM_W{1'b1}};
                    ovf_d       = 1'b1;
                  end else begin
                    params_d[i] = wide[PARAM_W-1:0];
                  end
                end
              end
            end else if (is_semi) begin
              seen_d  = 1'b1;
              state_d = CSI_PARAM;
              if (idx_q < NP_MAX) begin
                idx_d = idx_q + 1'b1;
                if (idx_q == NP_LAST) ovf_d = 1'b1;
              end
            end else if (is_colon || is_private) begin
              state_d = CSI_IGNORE;
            end else if (is_inter) begin
              inter_d      = b;
              have_inter_d = 1'b1;
              ovf_d        = ovf_q | have_inter_q;
              state_d      = CSI_INTER;
            end else begin
              emit      = 1'b1;
              emit_kind = KIND_CSI;
              clear     = 1'b1;
              state_d   = GROUND;
            end
          end
          CSI_INTER: begin
            if (is_inter) begin
              inter_d      = b;
              have_inter_d = 1'b1;
              ovf_d        = ovf_q | have_inter_q;
            end else if (b < 8'h40) begin
              state_d = CSI_IGNORE;
            end else begin
              emit      = 1'b1;
              emit_kind = KIND_CSI;
              clear     = 1'b1;
              state_d   = GROUND;
            end
          end
          CSI_IGNORE: begin
            if (is_final) begin
              state_d = GROUND;
              clear   = 1'b1;
            end
          end
          default: state_d = GROUND;
        endcase
      end
    end

    if (clear) begin
      for (int i = 0; i < MAX_PARAMS; i++) params_d[i] = '0;
      has_digit_d  = '0;
      idx_d        = '0;
      seen_d       = 1'b0;
      inter_d      = '0;
      have_inter_d = 1'b0;
      private_d    = '0;
      ovf_d        = 1'b0;
    end
  end

  assign nparams = !seen_q ? '0 : ((idx_q == NP_MAX) ? NP_MAX : idx_q + 1'b1);

  always_comb begin
    params_flat = '0;
    for (int i = 0; i < MAX_PARAMS; i++) params_flat[i*PARAM_W +: PARAM_W] = params_q[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the parameter slots are a handful of flops, not a RAM, so they reset with the rest.
      state_q      <= GROUND;
      for (int i = 0; i < MAX_PARAMS; i++) params_q[i] <= '0;
      has_digit_q  <= '0;
      idx_q        <= '0;
      seen_q       <= 1'b0;
      inter_q      <= '0;
      have_inter_q <= 1'b0;
      private_q    <= '0;
      ovf_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking updates keep every register sampling pre-edge values.
      state_q      <= state_d;
      params_q     <= params_d;
      has_digit_q  <= has_digit_d;
      idx_q        <= idx_d;
      seen_q       <= seen_d;
      inter_q      <= inter_d;
      have_inter_q <= have_inter_d;
      private_q    <= private_d;
      ovf_q        <= ovf_d;
    end
  end

  // ESC records reuse the CSI path: their params/private are already clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.cmd_valid    <= 1'b0;
      bus.cmd_kind     <= '0;
      bus.cmd_final    <= '0;
      bus.cmd_inter    <= '0;
      bus.cmd_private  <= '0;
      bus.cmd_nparams  <= '0;
      bus.cmd_params   <= '0;
      bus.cmd_default  <= '1;
      bus.cmd_overflow <= 1'b0;
    end else if (accept && emit) begin
      bus.cmd_valid <= 1'b1;
      bus.cmd_kind  <= emit_kind;
      bus.cmd_final <= b;
      if (emit_kind == KIND_PRINT) begin
        bus.cmd_inter    <= '0;
        bus.cmd_private  <= '0;
        bus.cmd_nparams  <= '0;
        bus.cmd_params   <= '0;
        bus.cmd_default  <= '1;
        bus.cmd_overflow <= 1'b0;
      end else begin
        bus.cmd_inter    <= inter_q;
        bus.cmd_private  <= private_q;
        bus.cmd_nparams  <= nparams;
        bus.cmd_params   <= params_flat;
        bus.cmd_default  <= ~has_digit_q;
        bus.cmd_overflow <= ovf_q;
      end
    end else if (bus.cmd_ready) begin
      bus.cmd_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_csi_sequence_parser.sv
// Scoreboard bench for csi_sequence_parser: a sequence-level model queues expected
// records on byte acceptance; a negedge monitor pops and compares on each handshake.
module tb_csi_sequence_parser;
  localparam int PW   = 8;
  localparam int MP   = 4;
  localparam int NPW  = $clog2(MP + 1);
  localparam int PMAX = (1 << PW) - 1;

  typedef struct packed {
    logic [1:0]       kind;
    logic [7:0]       fin;
    logic [7:0]       inter;
    logic [7:0]       priv;
    logic [NPW-1:0]   np;
    logic [MP*PW-1:0] params;
    logic [MP-1:0]    dflt;
    logic             ovf;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 1;
  int   mode = 0;
  logic [7:0] body[$];
  rec_t exp_q[$];
  rec_t held, e;
  bit   hold = 1'b0;

  csi_sequence_parser_if #(.PARAM_W(PW), .MAX_PARAMS(MP)) bus ();
  csi_sequence_parser #(.PARAM_W(PW), .MAX_PARAMS(MP)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic rec_t print_rec(input logic [7:0] b);
    rec_t r;
    r      = '0;
    r.fin  = b;
    r.dflt = '1;
    return r;
  endfunction

  function automatic rec_t esc_rec(input logic [7:0] b);
    rec_t r;
    r       = print_rec(b);
    r.kind  = 2'd1;
    r.inter = (body.size() > 0) ? body[$] : 8'h00;
    r.ovf   = body.size() > 1;
    return r;
  endfunction

  // Whole-sequence parse of the collected CSI body; returns 0 when it must be ignored.
  function automatic bit csi_rec(input logic [7:0] b, output rec_t r);
    logic [7:0] pstr[$];
    int p, ninter, field, v, nf;
    bit digits;
    r      = print_rec(b);
    r.kind = 2'd2;
    p      = 0;
    ninter = 0;
    if (body.size() > 0 && body[0] >= 8'h3C && body[0] <= 8'h3F) begin
      r.priv = body[0];
      p = 1;
    end
    while (p < body.size() && body[p] >= 8'h30) begin
      if (body[p] == 8'h3A || body[p] >= 8'h3C) return 1'b0;
      pstr.push_back(body[p]);
      p++;
    end
    while (p < body.size()) begin
      if (body[p] >= 8'h30) return 1'b0;
      r.inter = body[p];
      ninter++;
      p++;
    end
    if (ninter > 1) r.ovf = 1'b1;
    if (pstr.size() == 0) return 1'b1;
    field  = 0;
    v      = 0;
    digits = 1'b0;
    for (int k = 0; k <= pstr.size(); k++) begin
      if (k == pstr.size() || pstr[k] == ";") begin
        if (field < MP) begin
          if (v > PMAX) r.ovf = 1'b1;
          r.params[field*PW +: PW] = PW'((v > PMAX) ? PMAX : v);
          if (digits) r.dflt[field] = 1'b0;
        end
        field++;
        v = 0;
        digits = 1'b0;
      end else begin
        v = v * 10 + (int'(pstr[k]) - 48);
        if (v > PMAX) v = PMAX + 1;
        digits = 1'b1;
      end
    end
    nf = field;
    if (nf > MP) r.ovf = 1'b1;
    r.np = NPW'((nf > MP) ? MP : nf);
    return 1'b1;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    rec_t r;
    bit c1_csi, c1_can;
    c1_csi = 1'b0;
    c1_can = 1'b0;
`ifdef CSI_PARSER_C1_EN
    c1_csi = (b == 8'h9B);
    c1_can = (b == 8'h9C);
`endif
    if (b == 8'h18 || b == 8'h1A || c1_can) begin
      mode = 0; body.delete();
    end else if (b == 8'h1B) begin
      mode = 1; body.delete();
    end else if (c1_csi) begin
      mode = 2; body.delete();
    end else if (mode == 0 || b < 8'h20) begin
      exp_q.push_back(print_rec(b));
    end else if (b >= 8'h7F) begin
      // dropped inside sequences
    end else if (mode == 1) begin
      if (body.size() == 0 && b == 8'h5B) mode = 2;
      else if (b < 8'h30) body.push_back(b);
      else begin
        exp_q.push_back(esc_rec(b));
        mode = 0; body.delete();
      end
    end else if (b >= 8'h40) begin
      if (csi_rec(b, r)) exp_q.push_back(r);
      mode = 0; body.delete();
    end else begin
      body.push_back(b);
    end
  endtask

  function automatic rec_t cur_rec();
    rec_t r;
    r.kind   = bus.cmd_kind;
    r.fin    = bus.cmd_final;
    r.inter  = bus.cmd_inter;
    r.priv   = bus.cmd_private;
    r.np     = bus.cmd_nparams;
    r.params = bus.cmd_params;
    r.dflt   = bus.cmd_default;
    r.ovf    = bus.cmd_overflow;
    return r;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit acc;
    int n;
    acc = 1'b0;
    n   = 0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.in_valid = 1'b0;
    if (acc) model_byte(b);
    else begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got in_ready 0 for 200 cycles expected 1");
    end
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic esc(input string s);
    send_byte(8'h1B);
    send_str(s);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    mode = 0;
    body.delete();
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
    check("reset_drops_record", bus.cmd_valid, 1'b0);
  endtask

  function automatic logic [7:0] pick();
    logic [7:0] sp [5];
    sp = '{8'h7F, 8'h9B, 8'h9C, 8'h18, 8'h1A};
    case ($urandom_range(0, 15))
      0, 1:    return 8'h1B;
      2:       return "[";
      3, 4, 5: return 8'h30 + 8'($urandom_range(0, 9));
      6:       return ";";
      7:       return 8'h3C + 8'($urandom_range(0, 3));
      8:       return ":";
      9:       return 8'h20 + 8'($urandom_range(0, 15));
      10, 11:  return 8'h40 + 8'($urandom_range(0, 62));
      12:      return 8'($urandom_range(0, 31));
      13:      return sp[$urandom_range(0, 4)];
      14:      return 8'($urandom_range(0, 255));
      default: return "m";
    endcase
  endfunction

  initial begin
    bus.cmd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bus.cmd_ready = 1'b0;
        1:       bus.cmd_ready = 1'b1;
        default: bus.cmd_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      check("in_ready", bus.in_ready, !bus.cmd_valid || bus.cmd_ready);
      if (hold) begin
        check("hold_valid", bus.cmd_valid, 1'b1);
        check("hold_record", cur_rec(), held);
      end
      hold = bus.cmd_valid && !bus.cmd_ready;
      if (hold) held = cur_rec();
      if (bus.cmd_valid && bus.cmd_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_record got %0h expected none", cur_rec());
        end else begin
          e = exp_q.pop_front();
          check("kind", bus.cmd_kind, e.kind);
          check("final", bus.cmd_final, e.fin);
          check("inter", bus.cmd_inter, e.inter);
          check("private", bus.cmd_private, e.priv);
          check("nparams", bus.cmd_nparams, e.np);
          check("params", bus.cmd_params, e.params);
          check("default", bus.cmd_default, e.dflt);
          check("overflow", bus.cmd_overflow, e.ovf);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #2;
    check("rst_cmd_valid", bus.cmd_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_default", bus.cmd_default, {MP{1'b1}});
    check("rst_fields", {bus.cmd_kind, bus.cmd_final, bus.cmd_nparams, bus.cmd_params}, '0);
    rst = 1'b0;
    @(posedge clk);
    #2;

    send_byte("A");
    @(negedge clk);
    check("latency_valid", bus.cmd_valid, 1'b1);
    esc("[12;34H");
    esc("[?25l");
    esc("[999;1;2;3;4m");
    esc("[1");
    send_byte(8'h0D);
    send_str("2A");
    esc("[5");
    send_byte(8'h18);
    send_str("A");
    esc("[;5H");
    esc("(B");
    esc(" !F");
    esc("[1:2m");
    esc("[>1$p");
    send_byte(8'h9B);
    send_str("2J");
    wait_drain();

    ready_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    send_byte("X");
    fork
      send_byte("Y");
      begin
        repeat (4) @(negedge clk);
        check("bp_in_ready", bus.in_ready, 1'b0);
        check("bp_valid", bus.cmd_valid, 1'b1);
        ready_mode = 1;
      end
    join
    wait_drain();

    esc("[5");
    do_reset();
    ready_mode = 0;
    repeat (2) @(posedge clk);
    #2;
    send_byte("Z");
    do_reset();
    ready_mode = 1;
    send_str("Q");
    wait_drain();

    ready_mode = 2;
    repeat (2500) send_byte(pick());
    ready_mode = 1;
    wait_drain();
    check("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
